// File: rtl/cmlk_ddr_wr_sched.sv
// Two-channel DDR write scheduler: round-robin burst arbitration into per-channel frame slot rings.
// Optional build macro CMLK_SLOT_OVERWRITE_EN: overwrite the oldest slot instead of blocking when full.
module cmlk_ddr_wr_sched #(
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_WORDS = 262400,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter logic [31:0] SLOT_STRIDE = 32'h0020_0000,
  parameter logic [31:0] CH0_BASE    = 32'h0000_0000,
  parameter logic [31:0] CH1_BASE    = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ch0_rd_data,
  input  logic [31:0] ch1_rd_data,
  input  logic [11:0] ch0_rd_count,
  input  logic [11:0] ch1_rd_count,
  output logic        ch0_rd_en,
  output logic        ch1_rd_en,
  input  logic [1:0]  ch0_frame_type,
  input  logic [1:0]  ch1_frame_type,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [7:0]  cmd_len,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  input  logic [1:0]  slot_release,
  output logic        frame_done,
  output logic        frame_done_ch,
  output logic [2:0]  frame_done_slot,
  output logic [1:0]  frame_done_type,
  output logic [1:0]  slot_overrun
);

  localparam int unsigned OFF_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [11:0]       BL_CNT    = 12'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0]  BL_OFF    = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0]  FRAME_END = OFF_W'(FRAME_WORDS);
  localparam logic [2:0]        SLOT_MAX  = 3'(NUM_SLOTS - 1);
  localparam logic [3:0]        USED_MAX  = 4'(NUM_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;
  state_t state_q, state_d;

  logic [1:0][OFF_W-1:0] word_off_q;
  logic [1:0][2:0]       wr_slot_q;
  logic [1:0][3:0]       used_q;
  logic [1:0][1:0]       ftype_q;
  logic [1:0][11:0]      rd_cnt;
  logic [1:0]            elig, slot_ok, used_inc, used_dec;
  logic                  grant_q, grant_d, last_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  beat_acc;
  logic [OFF_W-1:0]      off_next;
  logic [11:0]           g_count;
  logic [31:0]           g_data;

  logic        cmd_valid_q, wlast_q;
  logic [31:0] cmd_addr_q;
  logic [7:0]  cmd_len_q;
  logic        frame_done_q, frame_done_ch_q;
  logic [2:0]  frame_done_slot_q;
  logic [1:0]  frame_done_type_q;

  assign rd_cnt   = {ch1_rd_count, ch0_rd_count};
  assign off_next = word_off_q[grant_q] + BL_OFF;

`ifdef CMLK_SLOT_OVERWRITE_EN
  logic [1:0] overrun_q;
  assign slot_ok      = 2'b11;
  assign slot_overrun = overrun_q;
`else
  assign slot_ok      = {used_q[1] < USED_MAX, used_q[0] < USED_MAX};
  assign slot_overrun = '0;
`endif

  // Slot availability only gates the start of a frame, never a frame in progress.
  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      elig[c]     = (rd_cnt[c] >= BL_CNT) && ((word_off_q[c] != '0) || slot_ok[c]);
      used_inc[c] = (state_q == S_DONE) && (grant_q == 1'(c));
      used_dec[c] = slot_release[c] && (used_q[c] != '0);
    end
    grant_d = (elig == 2'b11) ? ~last_q : elig[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = '0;
    case (state_q)
      S_IDLE: if (|elig) state_d = S_CMD;
      S_CMD:  if (cmd_ready) state_d = S_DATA;
      S_DATA: begin
        beat_d = beat_q;
        if (beat_acc) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = (off_next == FRAME_END) ? S_DONE : S_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    g_count   = grant_q ? ch1_rd_count : ch0_rd_count;
    g_data    = grant_q ? ch1_rd_data  : ch0_rd_data;
    wvalid    = (state_q == S_DATA) && (g_count != '0);
    beat_acc  = wvalid && wready;
    ch0_rd_en = beat_acc && !grant_q;
    ch1_rd_en = beat_acc &&  grant_q;
    wdata     = (state_q == S_DATA) ? g_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_off_q        <= '0;
      wr_slot_q         <= '0;
      used_q            <= '0;
      ftype_q           <= '0;
      grant_q           <= 1'b0;
      last_q            <= 1'b1;
      beat_q            <= '0;
      cmd_valid_q       <= 1'b0;
      cmd_addr_q        <= '0;
      cmd_len_q         <= '0;
      wlast_q           <= 1'b0;
      frame_done_q      <= 1'b0;
      frame_done_ch_q   <= 1'b0;
      frame_done_slot_q <= '0;
      frame_done_type_q <= '0;
`ifdef CMLK_SLOT_OVERWRITE_EN
      overrun_q         <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      beat_q       <= beat_d;
      wlast_q      <= (state_d == S_DATA) && (beat_d == LAST_BEAT);
      case (state_q)
        S_IDLE: if (|elig) begin
          grant_q     <= grant_d;
          last_q      <= grant_d;
          cmd_valid_q <= 1'b1;
          cmd_len_q   <= 8'(BURST_LEN - 1);
          cmd_addr_q  <= (grant_d ? CH1_BASE : CH0_BASE)
                       + (32'(wr_slot_q[grant_d]) * SLOT_STRIDE)
                       + (32'(word_off_q[grant_d]) << 2);
          if (word_off_q[grant_d] == '0) begin
            ftype_q[grant_d] <= grant_d ? ch1_frame_type : ch0_frame_type;
`ifdef CMLK_SLOT_OVERWRITE_EN
            if (used_q[grant_d] == USED_MAX) overrun_q[grant_d] <= 1'b1;
`endif
          end
        end
        S_CMD: if (cmd_ready) cmd_valid_q <= 1'b0;
        S_DATA: if (beat_acc && (beat_q == LAST_BEAT)) begin
          word_off_q[grant_q] <= (off_next == FRAME_END) ? '0 : off_next;
          if (off_next == FRAME_END) begin
            frame_done_q      <= 1'b1;
            frame_done_ch_q   <= grant_q;
            frame_done_slot_q <= wr_slot_q[grant_q];
            frame_done_type_q <= ftype_q[grant_q];
          end
        end
        S_DONE: wr_slot_q[grant_q] <= (wr_slot_q[grant_q] == SLOT_MAX) ? '0 : wr_slot_q[grant_q] + 1'b1;
        default: ;
      endcase
      // Simultaneous release and completion cancel; completion saturates at a full ring.
      for (int unsigned c = 0; c < 2; c++) begin
        if (used_inc[c] && !used_dec[c] && (used_q[c] != USED_MAX)) used_q[c] <= used_q[c] + 1'b1;
        else if (used_dec[c] && !used_inc[c])                     used_q[c] <= used_q[c] - 1'b1;
      end
    end
  end

  assign cmd_valid       = cmd_valid_q;
  assign cmd_addr        = cmd_addr_q;
  assign cmd_len         = cmd_len_q;
  assign wlast           = wlast_q;
  assign frame_done      = frame_done_q;
  assign frame_done_ch   = frame_done_ch_q;
  assign frame_done_slot = frame_done_slot_q;
  assign frame_done_type = frame_done_type_q;

endmodule

// File: tb/tb_cmlk_ddr_wr_sched.sv
// Randomized bench for cmlk_ddr_wr_sched against a transaction-level scheduler model.
// Honours CMLK_SLOT_OVERWRITE_EN when the same macro is given to the design.
module tb_cmlk_ddr_wr_sched;
  localparam int unsigned BL = 16;
  localparam int unsigned FW = 64;
  localparam int unsigned NS = 2;
  localparam logic [31:0] STRIDE = 32'h0020_0000;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ch0_rd_data, ch1_rd_data;
  logic [11:0] ch0_rd_count, ch1_rd_count;
  logic        ch0_rd_en, ch1_rd_en;
  logic [1:0]  ch0_frame_type, ch1_frame_type;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wdata;
  logic        wvalid, wready, wlast;
  logic [1:0]  slot_release;
  logic        frame_done, frame_done_ch;
  logic [2:0]  frame_done_slot;
  logic [1:0]  frame_done_type;
  logic [1:0]  slot_overrun;

  cmlk_ddr_wr_sched #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .NUM_SLOTS(NS),
    .SLOT_STRIDE(STRIDE), .CH0_BASE(B0), .CH1_BASE(B1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_rd_data(ch0_rd_data), .ch1_rd_data(ch1_rd_data),
    .ch0_rd_count(ch0_rd_count), .ch1_rd_count(ch1_rd_count),
    .ch0_rd_en(ch0_rd_en), .ch1_rd_en(ch1_rd_en),
    .ch0_frame_type(ch0_frame_type), .ch1_frame_type(ch1_frame_type),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .slot_release(slot_release),
    .frame_done(frame_done), .frame_done_ch(frame_done_ch),
    .frame_done_slot(frame_done_slot), .frame_done_type(frame_done_type),
    .slot_overrun(slot_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO contents (FWFT: head word visible on rd_data)
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic upd_fifo();
    ch0_rd_data  = (q0.size() != 0) ? q0[0] : 32'h0;
    ch1_rd_data  = (q1.size() != 0) ? q1[0] : 32'h0;
    ch0_rd_count = 12'(q0.size());
    ch1_rd_count = 12'(q1.size());
  endtask

  // Scheduler model: what the port must be doing in the current cycle
  typedef enum {M_IDLE, M_CMD, M_DATA, M_DONE} mph_t;
  mph_t ph, ph_n;
  int unsigned m_off[2], m_slot[2], m_used[2];
  logic [1:0]  m_type[2];
  logic [1:0]  exp_ovr;
  int          g, last;
  int unsigned beat;
  logic [31:0] exp_addr;
  int          nframes, nbursts;
  bit          rst_done, rst_now, rst_prev;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_off[c] = 0; m_slot[c] = 0; m_used[c] = 0; m_type[c] = 2'd0;
    end
    exp_ovr = 2'b00; g = 0; last = 1; beat = 0; ph = M_IDLE; ph_n = M_IDLE;
  endtask

  function automatic bit elig_m(int c);
    int  cnt;
    bit  slot_free;
    cnt = (c == 1) ? q1.size() : q0.size();
`ifdef CMLK_SLOT_OVERWRITE_EN
    slot_free = 1'b1;
`else
    slot_free = (m_used[c] < NS);
`endif
    return (cnt >= int'(BL)) && ((m_off[c] != 0) || slot_free);
  endfunction

  initial begin
    bit e0, e1, acc, inc, pop0, pop1, dec, ii, wv_exp;
    int cnt;
    logic [31:0] head;
    rst_n = 1'b0; cmd_ready = 1'b0; wready = 1'b0; slot_release = 2'b00;
    ch0_frame_type = 2'd1; ch1_frame_type = 2'd2;
    nframes = 0; nbursts = 0; rst_done = 0; rst_prev = 0; pop0 = 0; pop1 = 0;
    upd_fifo();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_addr", cmd_addr, 32'd0);
    check("rst_cmd_len", 32'(cmd_len), 32'd0);
    check("rst_wlast", 32'(wlast), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(slot_overrun), 32'd0);

    for (int cyc = 0; cyc < 9000; cyc++) begin
      // drive inputs for the coming edge
      rst_now = !rst_done && (nbursts == 12) && (ph == M_DATA) && (beat == 10);
      rst_n = !rst_now;
      if (rst_now) begin
        rst_done = 1; cmd_ready = 1'b0; wready = 1'b0; slot_release = 2'b00;
      end else if (cyc < 400) begin
        cmd_ready = 1'b1; wready = 1'b1; slot_release = 2'b00;
      end else begin
        cmd_ready = ($urandom_range(0, 99) < 60);
        wready    = ($urandom_range(0, 99) < 75);
        slot_release[0] = ($urandom_range(0, 119) == 0);
        slot_release[1] = ($urandom_range(0, 119) == 0);
      end
      if (q0.size() < 100 && $urandom_range(0, 1) == 1) q0.push_back($urandom);
      if (cyc >= 400 && q1.size() < 100 && $urandom_range(0, 1) == 1) q1.push_back($urandom);
      if ($urandom_range(0, 19) == 0) ch0_frame_type = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ch1_frame_type = 2'($urandom_range(0, 3));
      upd_fifo();
      #1;
      pop0 = 0; pop1 = 0; inc = 0;
      if (rst_now) begin
        model_reset();
      end else begin
        case (ph)
          M_IDLE: begin
            check("idle_wvalid", 32'(wvalid), 32'd0);
            e0 = elig_m(0); e1 = elig_m(1);
            ph_n = M_IDLE;
            if (e0 || e1) begin
              g = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
              last = g;
              exp_addr = (g == 1 ? B1 : B0) + 32'(m_slot[g]) * STRIDE + 32'(m_off[g] * 4);
              if (m_off[g] == 0) begin
                m_type[g] = (g == 1) ? ch1_frame_type : ch0_frame_type;
`ifdef CMLK_SLOT_OVERWRITE_EN
                if (m_used[g] == NS) exp_ovr[g] = 1'b1;
`endif
              end
              ph_n = M_CMD;
              nbursts++;
            end
          end
          M_CMD: begin
            check("cmd_wvalid", 32'(wvalid), 32'd0);
            beat = 0;
            ph_n = cmd_ready ? M_DATA : M_CMD;
          end
          M_DATA: begin
            cnt = (g == 1) ? q1.size() : q0.size();
            wv_exp = (cnt != 0);
            check("wvalid", 32'(wvalid), 32'(wv_exp));
            acc = wv_exp && wready;
            check("ch0_rd_en", 32'(ch0_rd_en), 32'(acc && g == 0));
            check("ch1_rd_en", 32'(ch1_rd_en), 32'(acc && g == 1));
            ph_n = M_DATA;
            if (acc) begin
              head = (g == 1) ? q1[0] : q0[0];
              check("wdata", wdata, head);
              if (g == 1) pop1 = 1; else pop0 = 1;
              if (beat == BL - 1) begin
                m_off[g] += BL;
                if (m_off[g] == FW) begin
                  m_off[g] = 0;
                  ph_n = M_DONE;
                end else begin
                  ph_n = M_IDLE;
                end
              end else begin
                beat++;
              end
            end
          end
          M_DONE: begin
            inc = 1;
            m_slot[g] = (m_slot[g] + 1) % NS;
            ph_n = M_IDLE;
          end
          default: ph_n = M_IDLE;
        endcase
        for (int c = 0; c < 2; c++) begin
          ii  = inc && (g == c);
          dec = slot_release[c] && (m_used[c] != 0);
          if (ii && !dec && m_used[c] < NS) m_used[c]++;
          else if (dec && !ii)              m_used[c]--;
        end
      end

      @(posedge clk);
      #1;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      upd_fifo();
      ph = ph_n;
      check("cmd_valid", 32'(cmd_valid), 32'(ph == M_CMD));
      if (ph == M_CMD) begin
        check("cmd_addr", cmd_addr, exp_addr);
        check("cmd_len", 32'(cmd_len), BL - 1);
      end
      check("frame_done", 32'(frame_done), 32'(ph == M_DONE));
      if (ph == M_DONE) begin
        nframes++;
        check("done_ch", 32'(frame_done_ch), 32'(g));
        check("done_slot", 32'(frame_done_slot), m_slot[g]);
        check("done_type", 32'(frame_done_type), 32'(m_type[g]));
      end
      check("wlast", 32'(wlast), 32'(ph == M_DATA && beat == BL - 1));
      check("slot_overrun", 32'(slot_overrun), 32'(exp_ovr));
      if (rst_now) begin
        check("midrst_cmd_addr", cmd_addr, 32'd0);
        check("midrst_cmd_len", 32'(cmd_len), 32'd0);
        check("midrst_wvalid", 32'(wvalid), 32'd0);
        check("midrst_wdata", wdata, 32'd0);
        check("midrst_rd_en", 32'({ch1_rd_en, ch0_rd_en}), 32'd0);
      end
    end
    check("frames_completed", 32'(nframes >= 6), 32'd1);
    check("midburst_reset_hit", 32'(rst_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmlk_ddr_wr_sched.md
# cmlk_ddr_wr_sched

Two-channel DDR write scheduler. It sits between two `img_packet` output FIFOs (first-word-fall-through) and a single DDR write-burst port. It arbitrates round-robin at burst granularity and places each channel's packetized frames into a ring of DDR frame slots. It reports frame completion to the DDR->EMMC stage, which returns slots by pulsing a release.

## Interface
- `BURST_LEN`, 64: words (32-bit) per DDR burst; must divide `FRAME_WORDS`.
- `FRAME_WORDS`, 262400: words per packetized frame (262144 data + 256 parity/info/flush).
- `NUM_SLOTS`, 4: frame slots per channel, 1..8.
- `SLOT_STRIDE`, 32'h0020_0000: byte distance between slots.
- `CH0_BASE`, 32'h0000_0000: channel-0 slot-0 byte address.
- `CH1_BASE`, 32'h0100_0000: channel-1 slot-0 byte address.
- `clk`  in  1  clock
- `rst_n`  in  1  reset rst_n, synchronous, active-low; clock clk
- `ch0_rd_data`, `ch1_rd_data`  in  32  FWFT FIFO head word
- `ch0_rd_count`, `ch1_rd_count`  in  12  FIFO occupancy in words
- `ch0_rd_en`, `ch1_rd_en`  out  1  FIFO pop
- `ch0_frame_type`, `ch1_frame_type`  in  2  `frame_type_o` of each packetizer
- `cmd_valid` / `cmd_ready`  out / in  1  burst command handshake
- `cmd_addr`  out  32  burst byte address
- `cmd_len`  out  8  `BURST_LEN-1`
- `wdata`  out  32  write data
- `wvalid` / `wready`  out / in  1  write data handshake
- `wlast`  out  1  last beat of burst
- `slot_release`  in  2  bit c: one slot of channel c freed by consumer
- `frame_done`  out  1  one-cycle pulse, frame fully written
- `frame_done_ch`  out  1  channel of completed frame
- `frame_done_slot`  out  3  slot index of completed frame
- `frame_done_type`  out  2  frame type sampled at that frame's first burst
- `slot_overrun`  out  2  sticky per channel; only set when the overwrite feature is compiled in

## Operation
- Per-channel state:
  - `wr_slot` (0..NUM_SLOTS-1, wraps)
  - `word_off` (0..FRAME_WORDS-1)
  - `used` (0..NUM_SLOTS)
  - latched frame type
- Eligible(c): `rd_count >= BURST_LEN`, and either `word_off != 0` or `used < NUM_SLOTS`. Blocking is decided only at frame start; a frame in progress is never stalled by slot count.
- Arbitration in IDLE: grant the single eligible channel. If both are eligible, grant the channel not granted last. The last-grant pointer resets to ch1, so ch0 wins first.
- The frame type is latched on the burst where `word_off == 0`.
- States:
  - IDLE: if any channel is eligible, register grant, `cmd_addr = CHc_BASE + wr_slot*SLOT_STRIDE + word_off*4`, go to CMD.
  - CMD: `cmd_valid=1`, held with stable fields until `cmd_ready`, then go to DATA.
  - DATA: `wdata` = granted `rd_data`; `wvalid` = granted `rd_count != 0`; `rd_en` = `wvalid & wready` on the granted channel only. Beats are counted; `wlast` is asserted on beat `BURST_LEN-1`. After the last accepted beat, `word_off += BURST_LEN`. If the result equals `FRAME_WORDS`, set `word_off` to 0 and go to DONE; otherwise go to IDLE.
  - DONE: pulse `frame_done` with ch/slot/type; `wr_slot` increments (wraps at `NUM_SLOTS`); `used` increments; return to IDLE.
- `slot_release[c]` decrements `used[c]`. Release together with increment in the same cycle: `used` unchanged. Release at `used==0`: ignored.
- Address arithmetic is 32-bit unsigned and wraps silently.

## Timing
- All outputs are registered except `wdata`, `wvalid`, `rd_en` (combinational from FIFO and `wready`).
- Reset: all outputs 0, state IDLE, all counters 0.
- Latency:
  - Eligibility seen in IDLE at cycle n: `cmd_valid` at n+1.
  - `cmd_ready` at cycle m: first beat possible at m+1.
  - Last beat at k: `frame_done` at k+1, or return to IDLE at k+1.
- Minimum burst period is `BURST_LEN + 2` cycles.
- Reset mid-burst abandons the burst; offsets, slots and `used` return to 0.

## Configuration
- `CMLK_SLOT_OVERWRITE_EN` defined:
  - Eligibility ignores `used`.
  - A frame started while `used == NUM_SLOTS` overwrites the oldest slot and sets `slot_overrun[c]` (sticky until reset).
  - `used` saturates at `NUM_SLOTS`.
- Undefined: channels block at frame start while all slots are used; `slot_overrun` is tied 0.

## Test plan
- Single channel:
  - Stimulus: ch0 `rd_count=64`, `cmd_ready`/`wready` held 1.
  - Required: `cmd_addr=0x0`, `cmd_len=63`, 64 beats, `wlast` on beat 64, next `cmd_addr=0x100`.
- Round-robin:
  - Stimulus: both channels hold ≥64 words.
  - Required: grants alternate ch0, ch1, ch0; ch1 first address `0x0100_0000`.
- Backpressure:
  - Stimulus: `cmd_ready` low for 5 cycles, `wready` toggling.
  - Required: `cmd_addr` stable throughout; exactly 64 pops; data order preserved.
- Frame wrap:
  - Stimulus: ch0 written for 4100 bursts.
  - Required: `frame_done` with ch=0, slot=0, type latched; 4101st burst at `0x0020_0000`.
- Slot full:
  - Stimulus: `NUM_SLOTS=2`, 2 frames completed with no release.
  - Required: ch0 blocks with data pending. One `slot_release[0]` pulse: next burst at `0x0` (slot 0 after wrap). With `CMLK_SLOT_OVERWRITE_EN`: no block, `slot_overrun[0]=1`.
- Reset mid-burst:
  - Stimulus: reset asserted at beat 30.
  - Required: all outputs 0 next cycle; first post-reset `cmd_addr=CH0_BASE`.
